// File: rtl/mixed_b_mem_arbiter_pkg.sv
// mixedInclude_package / mixed_b_mem_arb_package: B memory geometry plus arbiter types.
// No ports; BSIZE/BSIZE_LOG2 describe the B macro, the second package holds state, response and address types.
package mixedInclude_package;
  localparam int BSIZE = 10;
  localparam int BSIZE_LOG2 = 4;
endpackage

package mixed_b_mem_arb_package;
  import mixedInclude_package::*;
  typedef enum logic {INIT, RUN} state_t;
  typedef logic [BSIZE_LOG2-1:0] b_addr_t;
  typedef struct packed {
    logic [2:0] id;
    logic [31:0] data;
    logic err;
  } rsp_t;
endpackage

// File: rtl/mixed_b_mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick among eligible requesters.
// Ports: i_elig eligible vector, i_ptr search start, o_grant one-hot winner, o_idx winner index, o_any a winner exists.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  logic [NUM_REQ-1:0] w_rot;
  assign w_rot = NUM_REQ'({i_elig, i_elig} >> i_ptr);
  // Scan downwards so the closest eligible requester after the pointer is assigned last and wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
    o_grant = o_any ? NUM_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/mixed_b_mem_arbiter.sv
// mixed_b_mem_arbiter: clears the B memory, then shares its single port among NUM_REQ requesters.
// Ports: clk, rst (async, active-high); req_* per-requester valid/ready/we/addr/wdata;
// rsp_* held, backpressured read response (id, data, err); init_done; mem_* memory port and mem_rdata.
module mixed_b_mem_arbiter
  import mixedInclude_package::*;
  import mixed_b_mem_arb_package::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = 32,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][BSIZE_LOG2-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_wdata,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [ID_W-1:0]                      rsp_id,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic                                 rsp_err,
  output logic                                 init_done,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [BSIZE_LOG2-1:0]                mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  input  logic [DATA_W-1:0]                    mem_rdata
);
  state_t r_state, w_next;
  b_addr_t r_cnt, w_addr;
  logic [ID_W-1:0] r_ptr, r_rd_id, r_rsp_id, w_gidx;
  logic [DATA_W-1:0] r_rsp_data, w_wdata;
  logic [NUM_REQ-1:0] w_elig, w_grant;
  logic r_rd_inflight, r_rd_err, r_rsp_valid, r_rsp_err, r_init_done;
  logic w_any, w_we, w_err, w_init, w_acc;
  // Reads wait for an empty response path; writes never do.
  assign w_elig = (r_state == RUN) ? req_valid & (req_we | {NUM_REQ{~r_rd_inflight & ~r_rsp_valid}}) : '0;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );
  assign w_addr = req_addr[w_gidx];
  assign w_we = req_we[w_gidx];
  assign w_wdata = req_wdata[w_gidx];
  assign w_err = w_addr > b_addr_t'(BSIZE - 1);
  // The clear sequence is gated by rst so the port stays idle while reset is held.
  assign w_init = (r_state == INIT) & ~rst;
  assign w_acc = w_any & ~w_err;
  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign rsp_err = r_rsp_err;
  assign init_done = r_init_done;
  always_comb begin
    w_next = (r_state == INIT && r_cnt == b_addr_t'(BSIZE - 1)) ? RUN : r_state;
    mem_en = w_init | w_acc;
    mem_we = w_init | (w_acc & w_we);
    mem_addr = w_init ? r_cnt : w_acc ? w_addr : '0;
    mem_wdata = (w_acc & w_we) ? w_wdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_ptr <= '0;
      r_rd_inflight <= 1'b0;
      r_rd_id <= '0;
      r_rd_err <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id <= '0;
      r_rsp_data <= '0;
      r_rsp_err <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == INIT) r_cnt <= r_cnt + b_addr_t'(1);
      if (w_next == RUN) r_init_done <= 1'b1;
      if (w_any) r_ptr <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
      if (w_any & ~w_we) begin
        r_rd_inflight <= 1'b1;
        r_rd_id <= w_gidx;
        r_rd_err <= w_err;
      end
      if (r_rd_inflight) begin
        r_rd_inflight <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_id <= r_rd_id;
        r_rsp_data <= r_rd_err ? '0 : mem_rdata;
        r_rsp_err <= r_rd_err;
      end else if (r_rsp_valid & rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mixed_b_mem_arbiter.sv
// tb_mixed_b_mem_arbiter: directed vector table plus hand sequences for init, read latency and mid-run reset.
module tb_mixed_b_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_we = '0;
  logic [1:0][3:0] req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, init_done;
  logic [0:0] rsp_id;
  logic [31:0] rsp_data, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [3:0] mem_addr;
  int total = 0;
  int bad = 0;

  mixed_b_mem_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .init_done(init_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: unwritten words read as junk, and rdata is junk except the cycle after a read.
  logic [31:0] mem [16];
  logic [15:0] wr_seen = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_seen[mem_addr] <= 1'b1;
    end
    mem_rdata <= (mem_en && !mem_we) ? (wr_seen[mem_addr] ? mem[mem_addr] : 32'hBAD0_0000 | 32'(mem_addr)) : 32'h0BAD_F00D;
  end

  typedef struct {
    logic [1:0] v, we;
    logic [3:0] a0, a1;
    logic [31:0] d0, d1;
    logic rr;
    logic [1:0] rdy;
    logic en, mwe;
    logic [3:0] ma;
    logic [31:0] mwd;
    logic rv;
    logic rid;
    logic [31:0] rd;
    logic re;
  } vec_t;
  vec_t tv [31];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_init();
    req_valid = 2'b11;
    req_we = 2'b11;
    req_addr[0] = 4'd15;
    req_addr[1] = 4'd15;
    for (int c = 0; c < 10; c++) begin
      #1 chk($sformatf("init%0d", c), {mem_en, mem_we, mem_addr, mem_wdata, init_done, req_ready}, {1'b1, 1'b1, 4'(c), 32'h0, 1'b0, 2'b00});
      @(negedge clk);
    end
    #1 chk("init_done", {init_done, req_ready, mem_en}, {1'b1, 2'b01, 1'b0});
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] ed);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_we = 2'b00;
    req_addr[0] = a;
    #1 chk($sformatf("rd_grant%0d", a), {req_ready, mem_en, mem_we, mem_addr}, {2'b01, 1'b1, 1'b0, a});
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk($sformatf("rd_wait%0d", a), rsp_valid, 1'b0);
    @(negedge clk);
    #1 chk($sformatf("rd_rsp%0d", a), {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, 1'b0, ed, 1'b0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{2'b11, 2'b11, 4'd3, 4'd3, 32'hA5A50000, 32'hA5A50001, 1'b1, 2'b10, 1'b1, 1'b1, 4'd3, 32'hA5A50001, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[1]  = '{2'b11, 2'b11, 4'd3, 4'd3, 32'hA5A50002, 32'hA5A50003, 1'b1, 2'b01, 1'b1, 1'b1, 4'd3, 32'hA5A50002, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[2]  = '{2'b11, 2'b11, 4'd3, 4'd3, 32'hA5A50004, 32'hA5A50005, 1'b1, 2'b10, 1'b1, 1'b1, 4'd3, 32'hA5A50005, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[3]  = '{2'b11, 2'b11, 4'd3, 4'd3, 32'hA5A50006, 32'hA5A50007, 1'b1, 2'b01, 1'b1, 1'b1, 4'd3, 32'hA5A50006, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[4]  = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[5]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[6]  = '{2'b11, 2'b10, 4'd5, 4'd7, 32'h0, 32'h70, 1'b0, 2'b10, 1'b1, 1'b1, 4'd7, 32'h70, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[7]  = '{2'b11, 2'b10, 4'd5, 4'd7, 32'h0, 32'h71, 1'b0, 2'b10, 1'b1, 1'b1, 4'd7, 32'h71, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[8]  = '{2'b11, 2'b10, 4'd5, 4'd7, 32'h0, 32'h72, 1'b0, 2'b10, 1'b1, 1'b1, 4'd7, 32'h72, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[9]  = '{2'b11, 2'b10, 4'd5, 4'd7, 32'h0, 32'h73, 1'b1, 2'b10, 1'b1, 1'b1, 4'd7, 32'h73, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[10] = '{2'b11, 2'b10, 4'd5, 4'd7, 32'h0, 32'h74, 1'b1, 2'b01, 1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 32'hA5A50006, 1'b0};
    tv[11] = '{2'b10, 2'b10, 4'd5, 4'd7, 32'h0, 32'h75, 1'b1, 2'b10, 1'b1, 1'b1, 4'd7, 32'h75, 1'b0, 1'b0, 32'hA5A50006, 1'b0};
    tv[12] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[13] = '{2'b10, 2'b10, 4'd0, 4'd12, 32'h0, 32'hDEAD, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[14] = '{2'b10, 2'b00, 4'd0, 4'd12, 32'h0, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[15] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[16] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1};
    tv[17] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1};
    tv[18] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tv[19] = '{2'b01, 2'b01, 4'd9, 4'd0, 32'h1234, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 4'd9, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b1};
    tv[20] = '{2'b01, 2'b00, 4'd9, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 4'd9, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tv[21] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    tv[22] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h1234, 1'b0};
    tv[23] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h1234, 1'b0};
    tv[24] = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, 32'h1234, 1'b0};
    tv[25] = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h1234, 1'b0};
    tv[26] = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[27] = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, 32'hA5A50006, 1'b0};
    tv[28] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'hA5A50006, 1'b0};
    tv[29] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'hA5A50006, 1'b0};
    tv[30] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'hA5A50006, 1'b0};

    req_valid = 2'b11;
    req_we = 2'b11;
    repeat (2) @(negedge clk);
    #1 chk("reset", {req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_id, rsp_data, rsp_err, init_done}, '0);
    @(negedge clk);
    rst = 1'b0;
    check_init();
    for (int a = 0; a < 10; a++) do_read(4'(a), 32'h0);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      req_valid = tv[i].v;
      req_we = tv[i].we;
      req_addr[0] = tv[i].a0;
      req_addr[1] = tv[i].a1;
      req_wdata[0] = tv[i].d0;
      req_wdata[1] = tv[i].d1;
      rsp_ready = tv[i].rr;
      #1 chk($sformatf("row%0d", i),
             {req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_id, rsp_data, rsp_err},
             {tv[i].rdy, tv[i].en, tv[i].mwe, tv[i].ma, tv[i].mwd, tv[i].rv, tv[i].rid, tv[i].rd, tv[i].re});
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_we = 2'b00;
    req_addr[0] = 4'd7;
    #1 chk("mid_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 chk("mid_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h75});
    rst = 1'b1;
    #1 chk("mid_rst", {req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_id, rsp_data, rsp_err, init_done}, '0);
    @(negedge clk);
    rst = 1'b0;
    check_init();
    do_read(4'd3, 32'h0);
    do_read(4'd7, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
